// File: rtl/geofence_poly_pkg.sv
// geofence_poly_pkg
//   Shared types and helpers for the convex-polygon geofence engine.
//   - state_t      : frame FSM states (LOAD, SORT, TEST, DONE)
//   - cross_w()    : full-precision cross-product result width for a coordinate width
//   - n_vert_legal : legal vertex-count range check used at elaboration
package geofence_poly_pkg;

   typedef enum logic [1:0] {LOAD, SORT, TEST, DONE} state_t;

   // Coordinate differences need COORD_W+1 signed bits, their products
   // 2*COORD_W+2, and the difference of two products one more bit.
   function automatic int cross_w(input int coord_w);
      return 2 * coord_w + 3;
   endfunction

   function automatic bit n_vert_legal(input int n);
      return (n >= 3) && (n <= 15);
   endfunction

endpackage

// File: rtl/geofence_poly_if.sv
// geofence_poly_if
//   Beat-in / result-out bus of the geofence engine.
//   in_valid, X, Y      : producer -> engine, one coordinate pair per beat
//   in_ready            : engine -> producer, high while frames are being loaded
//   out_valid, is_inside: engine -> consumer, one-cycle result strobe and result
//   master modport: frame producer / result consumer; slave modport: the engine.
interface geofence_poly_if #(
   parameter int COORD_W = 10
);
   logic               in_valid;
   logic               in_ready;
   logic [COORD_W-1:0] X;
   logic [COORD_W-1:0] Y;
   logic               out_valid;
   logic               is_inside;

   modport master (output in_valid, X, Y, input in_ready, out_valid, is_inside);
   modport slave  (input in_valid, X, Y, output in_ready, out_valid, is_inside);
endinterface

// File: rtl/geofence_poly_cross.sv
// geofence_poly_cross
//   Combinational signed cross product cr(a,b,c) = (b-a) x (c-a), carried at
//   full precision so no coordinate combination can overflow.
//   ax_i..cy_i : unsigned COORD_W coordinates of points a, b, c
//   cr_o       : signed cross_w(COORD_W) result; >0 means c is left of a->b
module geofence_poly_cross
   import geofence_poly_pkg::*;
#(
   parameter int  COORD_W = 10,
   localparam int CW      = cross_w(COORD_W)
) (
   input  logic [COORD_W-1:0]  ax_i,
   input  logic [COORD_W-1:0]  ay_i,
   input  logic [COORD_W-1:0]  bx_i,
   input  logic [COORD_W-1:0]  by_i,
   input  logic [COORD_W-1:0]  cx_i,
   input  logic [COORD_W-1:0]  cy_i,
   output logic signed [CW-1:0] cr_o
);
   localparam int DW = COORD_W + 1;
   localparam int PW = 2 * COORD_W + 2;

   logic signed [DW-1:0] dbx, dby, dcx, dcy;
   logic signed [PW-1:0] p_bc, p_cb;

   assign dbx = $signed({1'b0, bx_i}) - $signed({1'b0, ax_i});
   assign dby = $signed({1'b0, by_i}) - $signed({1'b0, ay_i});
   assign dcx = $signed({1'b0, cx_i}) - $signed({1'b0, ax_i});
   assign dcy = $signed({1'b0, cy_i}) - $signed({1'b0, ay_i});

   // Size casts of signed operands sign-extend before the multiply.
   assign p_bc = PW'(dbx) * PW'(dcy);
   assign p_cb = PW'(dcx) * PW'(dby);
   assign cr_o = CW'(p_bc) - CW'(p_cb);
endmodule

// File: rtl/geofence_poly.sv
// geofence_poly
//   Point-in-convex-polygon engine. A frame is the test point P followed by
//   N_VERT unordered vertices. The vertices are bubble-sorted by angle about
//   V0 (counter-clockwise), then P is tested against each edge with early exit.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : slave side of geofence_poly_if (in_valid/in_ready/X/Y in,
//           out_valid/is_inside out)
module geofence_poly
   import geofence_poly_pkg::*;
#(
   parameter int N_VERT      = 6,
   parameter int COORD_W     = 10,
   parameter bit EDGE_INSIDE = 1'b1
) (
   input  logic           clk,
   input  logic           reset,
   geofence_poly_if.slave bus
);
   if (!n_vert_legal(N_VERT)) begin : g_bad_nvert
      $error("geofence_poly: N_VERT must be in 3..15");
   end

   localparam int IW = $clog2(N_VERT);
   localparam int BW = $clog2(N_VERT + 1);
   localparam int CW = cross_w(COORD_W);

   localparam logic [BW-1:0] LAST_BEAT = BW'(N_VERT);
   localparam logic [IW-1:0] LAST_I    = IW'(N_VERT - 1);
   localparam logic [IW-1:0] LAST_J    = IW'(N_VERT - 2);
   localparam logic [IW-1:0] LAST_PASS = IW'(N_VERT - 2);
   localparam logic [IW-1:0] FIRST_J   = IW'(1);

   state_t             state_q;
   logic [BW-1:0]      beat_q;
   logic [IW-1:0]      pass_q;
   logic [IW-1:0]      idx_q;     // j during SORT, i during TEST
   logic               swapped_q;
   logic               in_ready_q;
   logic               out_valid_q;
   logic               is_inside_q;

   logic [COORD_W-1:0] vx_q [N_VERT];
   logic [COORD_W-1:0] vy_q [N_VERT];
   logic [COORD_W-1:0] px_q, py_q;

   logic               accept;
   logic [IW-1:0]      idx_nx;
   logic [IW-1:0]      wr_idx;
   logic [COORD_W-1:0] ax, ay, bx, by, cx, cy;
   logic signed [CW-1:0] cr_s;
   logic               cr_neg, cr_zero, edge_fail, swap_d;

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.is_inside = is_inside_q;

   // in_ready_q is high exactly in LOAD, so accept implies LOAD.
   assign accept = bus.in_valid && in_ready_q;

   // (idx+1) mod N_VERT; in SORT idx <= N_VERT-2, so it never wraps there.
   assign idx_nx = (idx_q == LAST_I) ? '0 : idx_q + 1'b1;
   assign wr_idx = IW'(beat_q - 1'b1);

   // One cross-product unit: SORT compares V[j], V[j+1] around V0,
   // TEST checks P against edge V[i] -> V[i+1].
   always_comb begin
      ax = vx_q[0];
      ay = vy_q[0];
      bx = vx_q[idx_q];
      by = vy_q[idx_q];
      cx = vx_q[idx_nx];
      cy = vy_q[idx_nx];
      if (state_q == TEST) begin
         ax = vx_q[idx_q];
         ay = vy_q[idx_q];
         bx = vx_q[idx_nx];
         by = vy_q[idx_nx];
         cx = px_q;
         cy = py_q;
      end
   end

   geofence_poly_cross #(.COORD_W(COORD_W)) u_cross (
      .ax_i (ax), .ay_i (ay),
      .bx_i (bx), .by_i (by),
      .cx_i (cx), .cy_i (cy),
      .cr_o (cr_s)
   );

   assign cr_neg    = cr_s[CW-1];
   assign cr_zero   = (cr_s == '0);
   assign edge_fail = cr_neg || (cr_zero && !EDGE_INSIDE);
   assign swap_d    = (state_q == SORT) && cr_neg;

   // Vertex/point file: loaded by beats, reordered in place by the sort.
   always_ff @(posedge clk) begin
      if (accept) begin
         if (beat_q == '0) begin
            px_q <= bus.X;
            py_q <= bus.Y;
         end else begin
            vx_q[wr_idx] <= bus.X;
            vy_q[wr_idx] <= bus.Y;
         end
      end else if (swap_d) begin
         vx_q[idx_q]  <= vx_q[idx_nx];
         vy_q[idx_q]  <= vy_q[idx_nx];
         vx_q[idx_nx] <= vx_q[idx_q];
         vy_q[idx_nx] <= vy_q[idx_q];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= LOAD;
         beat_q      <= '0;
         pass_q      <= '0;
         idx_q       <= '0;
         swapped_q   <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         is_inside_q <= 1'b0;
      end else begin
         out_valid_q <= 1'b0;
         case (state_q)
            LOAD: begin
               if (accept) begin
                  beat_q <= beat_q + 1'b1;
                  if (beat_q == LAST_BEAT) begin
                     state_q    <= SORT;
                     in_ready_q <= 1'b0;
                     beat_q     <= '0;
                     idx_q      <= FIRST_J;
                     pass_q     <= '0;
                     swapped_q  <= 1'b0;
                  end
               end
            end
            SORT: begin
               if (idx_q == LAST_J) begin
                  // A clean pass means sorted; the pass cap bounds degenerate input.
                  if (!(swapped_q || swap_d) || (pass_q == LAST_PASS)) begin
                     state_q <= TEST;
                     idx_q   <= '0;
                  end else begin
                     pass_q    <= pass_q + 1'b1;
                     idx_q     <= FIRST_J;
                     swapped_q <= 1'b0;
                  end
               end else begin
                  idx_q     <= idx_q + 1'b1;
                  swapped_q <= swapped_q || swap_d;
               end
            end
            TEST: begin
               if (edge_fail) begin
                  is_inside_q <= 1'b0;
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end else if (idx_q == LAST_I) begin
                  is_inside_q <= 1'b1;
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            DONE: begin
               state_q    <= LOAD;
               in_ready_q <= 1'b1;
               idx_q      <= '0;
            end
            default: state_q <= LOAD;
         endcase
      end
   end
endmodule

// File: tb/tb_geofence_poly.sv
// tb_geofence_poly
//   Three engines: dut0 (6 vertices, 10-bit, edge=inside), dut1 (same, edge=outside)
//   fed identical frames, and dut2 (4 vertices, 12-bit). Expected results come
//   from a hull-edge model: every vertex pair with all other vertices strictly
//   to its left is a boundary edge, and P is inside iff it is not right of any.
module tb_geofence_poly;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   geofence_poly_if #(.COORD_W(10)) bus0 ();
   geofence_poly_if #(.COORD_W(10)) bus1 ();
   geofence_poly_if #(.COORD_W(12)) bus2 ();

   logic       a_valid = 1'b0;
   logic [9:0] a_x = '0, a_y = '0;
   logic       b_valid = 1'b0;
   logic [11:0] b_x = '0, b_y = '0;

   assign bus0.in_valid = a_valid;
   assign bus0.X        = a_x;
   assign bus0.Y        = a_y;
   assign bus1.in_valid = a_valid;
   assign bus1.X        = a_x;
   assign bus1.Y        = a_y;
   assign bus2.in_valid = b_valid;
   assign bus2.X        = b_x;
   assign bus2.Y        = b_y;

   geofence_poly #(.N_VERT(6), .COORD_W(10), .EDGE_INSIDE(1'b1)) dut0 (.clk(clk), .reset(rst_n), .bus(bus0));
   geofence_poly #(.N_VERT(6), .COORD_W(10), .EDGE_INSIDE(1'b0)) dut1 (.clk(clk), .reset(rst_n), .bus(bus1));
   geofence_poly #(.N_VERT(4), .COORD_W(12), .EDGE_INSIDE(1'b1)) dut2 (.clk(clk), .reset(rst_n), .bus(bus2));

   logic [2:0] ov, rd, ins;
   assign ov  = {bus2.out_valid, bus1.out_valid, bus0.out_valid};
   assign rd  = {bus2.in_ready,  bus1.in_ready,  bus0.in_ready};
   assign ins = {bus2.is_inside, bus1.is_inside, bus0.is_inside};

   int checks = 0;
   int errors = 0;

   // Current frame
   int fn;
   int fx [15];
   int fy [15];
   int fpx, fpy;

   // Observations of the last frame
   int r_ins [3];
   int r_lat [3];
   int r_pulses [3];
   int r_rdy_bad;
   int r_timeout;

   function automatic longint cr(input longint ax, input longint ay, input longint bx,
                                 input longint by, input longint cx, input longint cy);
      return (bx - ax) * (cy - ay) - (cx - ax) * (by - ay);
   endfunction

   function automatic int model_inside(input bit ei);
      bit     hull;
      longint s;
      for (int a = 0; a < fn; a++)
         for (int b = 0; b < fn; b++)
            if (a != b) begin
               hull = 1'b1;
               for (int v = 0; v < fn; v++)
                  if (v != a && v != b && cr(fx[a], fy[a], fx[b], fy[b], fx[v], fy[v]) <= 0)
                     hull = 1'b0;
               if (hull) begin
                  s = cr(fx[a], fy[a], fx[b], fy[b], fpx, fpy);
                  if (s < 0 || (s == 0 && !ei)) return 0;
               end
            end
      return 1;
   endfunction

   function automatic bit ei_of(input int d);
      return (d != 1);
   endfunction

   task automatic set_in(input int sel, input bit v, input int x, input int y);
      if (sel == 0) begin
         a_valid = v; a_x = 10'(x); a_y = 10'(y);
      end else begin
         b_valid = v; b_x = 12'(x); b_y = 12'(y);
      end
   endtask

   // Polygons stored counter-clockwise: 0 hex A, 1 hex B, 2 square, 3 diamond.
   task automatic load_poly(input int which);
      int px [4][6] = '{'{100, 300, 400, 300, 100,   0},
                        '{512,1023,1023, 512,   0,   0},
                        '{  0,4095,4095,   0,   0,   0},
                        '{2048,4095,2048,  0,   0,   0}};
      int py [4][6] = '{'{100, 100, 250, 400, 400, 250},
                        '{  0, 300, 700,1023, 700, 300},
                        '{  0,   0,4095,4095,   0,   0},
                        '{  0,2048,4095,2048,   0,   0}};
      fn = (which < 2) ? 6 : 4;
      for (int k = 0; k < fn; k++) begin
         fx[k] = px[which][k];
         fy[k] = py[which][k];
      end
   endtask

   task automatic load_given_hex();
      int gx [6] = '{300, 100,   0, 400, 100, 300};
      int gy [6] = '{100, 400, 250, 250, 100, 400};
      fn = 6;
      for (int k = 0; k < 6; k++) begin
         fx[k] = gx[k];
         fy[k] = gy[k];
      end
   endtask

   // Picks P (vertex, edge midpoint or random) from the ordered polygon, then shuffles.
   task automatic prep_random(input int which, input int rmax);
      int mode, k, j, t;
      load_poly(which);
      mode = $urandom_range(0, 3);
      k = $urandom_range(0, fn - 1);
      case (mode)
         0: begin fpx = fx[k]; fpy = fy[k]; end
         1: begin
            fpx = (fx[k] + fx[(k + 1) % fn]) / 2;
            fpy = (fy[k] + fy[(k + 1) % fn]) / 2;
         end
         default: begin
            fpx = $urandom_range(0, rmax);
            fpy = $urandom_range(0, rmax);
         end
      endcase
      for (int i = fn - 1; i > 0; i--) begin
         j = $urandom_range(0, i);
         t = fx[i]; fx[i] = fx[j]; fx[j] = t;
         t = fy[i]; fy[i] = fy[j]; fy[j] = t;
      end
   endtask

   task automatic send_beats(input int sel, input bit gaps);
      int w, g;
      r_timeout = 0;
      for (int b = 0; b <= fn; b++) begin
         if (gaps) begin
            g = $urandom_range(0, 3);
            repeat (g) begin
               set_in(sel, 1'b0, $urandom_range(0, 1023), $urandom_range(0, 1023));
               @(negedge clk);
            end
         end
         if (b == 0) set_in(sel, 1'b1, fpx, fpy);
         else        set_in(sel, 1'b1, fx[b-1], fy[b-1]);
         w = 0;
         while (!(sel != 0 ? rd[2] : (rd[0] && rd[1]))) begin
            @(negedge clk);
            w++;
            if (w > 100) begin r_timeout = 1; break; end
         end
         @(negedge clk);
      end
      set_in(sel, 1'b0, 0, 0);
   endtask

   task automatic collect(input int sel);
      int lo, hi, k;
      bit seen [3];
      bit done;
      lo = (sel != 0) ? 2 : 0;
      hi = (sel != 0) ? 2 : 1;
      for (int d = 0; d < 3; d++) begin
         r_ins[d] = -1; r_lat[d] = -1; r_pulses[d] = 0; seen[d] = 1'b0;
      end
      r_rdy_bad = 0;
      k = 0;
      done = 1'b0;
      while (!done && k < 200) begin
         k++;
         @(negedge clk);
         for (int d = lo; d <= hi; d++) begin
            if (!seen[d]) begin
               if (rd[d] !== 1'b0) r_rdy_bad++;
               if (ov[d] === 1'b1) begin
                  seen[d] = 1'b1; r_ins[d] = int'(ins[d]); r_lat[d] = k; r_pulses[d]++;
               end
            end else if (ov[d] !== 1'b0) r_pulses[d]++;
         end
         done = seen[lo] && seen[hi];
      end
      if (!done) r_timeout = 1;
      @(negedge clk);
      for (int d = lo; d <= hi; d++) begin
         if (ov[d] !== 1'b0) r_pulses[d]++;
         if (rd[d] !== 1'b1) r_rdy_bad++;
      end
   endtask

   task automatic run_frame(input int sel, input bit gaps);
      send_beats(sel, gaps);
      collect(sel);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      set_in(0, 1'b0, 0, 0);
      set_in(1, 1'b0, 0, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         checks++;
         if (rd[d] !== 1'b1) begin errors++; $display("FAIL reset_in_ready dut%0d: got %b expected 1", d, rd[d]); end
         checks++;
         if (ov[d] !== 1'b0) begin errors++; $display("FAIL reset_out_valid dut%0d: got %b expected 0", d, ov[d]); end
         checks++;
         if (ins[d] !== 1'b0) begin errors++; $display("FAIL reset_is_inside dut%0d: got %b expected 0", d, ins[d]); end
      end
   endtask

   task automatic test_inside();
      load_given_hex();
      fpx = 200; fpy = 250;
      run_frame(0, 1'b0);
      checks++;
      if (r_timeout !== 0) begin errors++; $display("FAIL inside_timeout: got %0d expected 0", r_timeout); end
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (r_pulses[d] !== 1) begin errors++; $display("FAIL inside_pulses dut%0d: got %0d expected 1", d, r_pulses[d]); end
         checks++;
         if (r_ins[d] !== 1) begin errors++; $display("FAIL inside_result dut%0d: got %0d expected 1", d, r_ins[d]); end
      end
   endtask

   task automatic test_outside();
      load_given_hex();
      fpx = 500; fpy = 250;
      run_frame(0, 1'b0);
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (r_ins[d] !== 0) begin errors++; $display("FAIL outside_result dut%0d: got %0d expected 0", d, r_ins[d]); end
         checks++;
         if (r_lat[d] < 1 || r_lat[d] > 23) begin
            errors++; $display("FAIL outside_latency dut%0d: got %0d expected 1..23", d, r_lat[d]);
         end
      end
   endtask

   task automatic test_edge();
      load_given_hex();
      fpx = 200; fpy = 100;
      run_frame(0, 1'b0);
      checks++;
      if (r_ins[0] !== 1) begin errors++; $display("FAIL edge_inclusive dut0: got %0d expected 1", r_ins[0]); end
      checks++;
      if (r_ins[1] !== 0) begin errors++; $display("FAIL edge_exclusive dut1: got %0d expected 0", r_ins[1]); end
   endtask

   task automatic test_max_coord();
      int sx [4] = '{0, 4095, 4095,    0};
      int sy [4] = '{0, 4095,    0, 4095};
      int qx [2] = '{4095, 4095};
      int qy [2] = '{2048, 4095};
      fn = 4;
      for (int k = 0; k < 4; k++) begin fx[k] = sx[k]; fy[k] = sy[k]; end
      for (int t = 0; t < 2; t++) begin
         fpx = qx[t]; fpy = qy[t];
         run_frame(1, 1'b0);
         checks++;
         if (r_pulses[2] !== 1) begin errors++; $display("FAIL maxcoord_pulses p%0d: got %0d expected 1", t, r_pulses[2]); end
         checks++;
         if (r_ins[2] !== 1) begin errors++; $display("FAIL maxcoord_result p%0d: got %0d expected 1", t, r_ins[2]); end
      end
   endtask

   task automatic test_back_to_back();
      int exp;
      for (int f = 0; f < 2; f++) begin
         prep_random($urandom_range(0, 1), 1023);
         run_frame(0, 1'b1);
         checks++;
         if (r_timeout !== 0) begin errors++; $display("FAIL b2b_timeout f%0d: got %0d expected 0", f, r_timeout); end
         checks++;
         if (r_rdy_bad !== 0) begin errors++; $display("FAIL b2b_in_ready f%0d: got %0d bad cycles expected 0", f, r_rdy_bad); end
         for (int d = 0; d < 2; d++) begin
            exp = model_inside(ei_of(d));
            checks++;
            if (r_pulses[d] !== 1) begin errors++; $display("FAIL b2b_pulses f%0d dut%0d: got %0d expected 1", f, d, r_pulses[d]); end
            checks++;
            if (r_ins[d] !== exp) begin
               errors++; $display("FAIL b2b_result f%0d dut%0d P=(%0d,%0d): got %0d expected %0d", f, d, fpx, fpy, r_ins[d], exp);
            end
         end
      end
   endtask

   task automatic test_random();
      int exp, sel, lo, hi;
      for (int f = 0; f < 30; f++) begin
         sel = (f < 18) ? 0 : 1;
         if (sel == 0) prep_random($urandom_range(0, 1), ($urandom_range(0, 1) != 0) ? 450 : 1023);
         else          prep_random($urandom_range(2, 3), 4095);
         run_frame(sel, $urandom_range(0, 1) != 0);
         lo = (sel != 0) ? 2 : 0;
         hi = (sel != 0) ? 2 : 1;
         checks++;
         if (r_timeout !== 0 || r_rdy_bad !== 0) begin
            errors++; $display("FAIL rand_handshake f%0d: got timeout=%0d rdybad=%0d expected 0,0", f, r_timeout, r_rdy_bad);
         end
         for (int d = lo; d <= hi; d++) begin
            exp = model_inside(ei_of(d));
            checks++;
            if (r_pulses[d] !== 1) begin errors++; $display("FAIL rand_pulses f%0d dut%0d: got %0d expected 1", f, d, r_pulses[d]); end
            checks++;
            if (r_ins[d] !== exp) begin
               errors++; $display("FAIL rand_result f%0d dut%0d P=(%0d,%0d): got %0d expected %0d", f, d, fpx, fpy, r_ins[d], exp);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      int pulses, exp;
      load_given_hex();
      fpx = 200; fpy = 250;
      send_beats(0, 1'b0);
      repeat (3) @(negedge clk);
      checks++;
      if (rd[0] !== 1'b0) begin errors++; $display("FAIL midreset_busy: got in_ready %b expected 0", rd[0]); end
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         checks++;
         if (rd[d] !== 1'b1) begin errors++; $display("FAIL midreset_in_ready dut%0d: got %b expected 1", d, rd[d]); end
      end
      pulses = 0;
      repeat (40) begin
         @(negedge clk);
         if (ov !== 3'b000) pulses++;
      end
      checks++;
      if (pulses !== 0) begin errors++; $display("FAIL midreset_no_result: got %0d pulses expected 0", pulses); end
      fpx = 500; fpy = 250;
      run_frame(0, 1'b1);
      for (int d = 0; d < 2; d++) begin
         exp = model_inside(ei_of(d));
         checks++;
         if (r_pulses[d] !== 1 || r_ins[d] !== exp) begin
            errors++; $display("FAIL midreset_next_frame dut%0d: got pulses=%0d result=%0d expected 1,%0d", d, r_pulses[d], r_ins[d], exp);
         end
      end
   endtask

   initial begin
      test_reset();
      test_inside();
      test_outside();
      test_edge();
      test_max_coord();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end
endmodule
